cache_mem_arbiter: RTL

//  Shares one physical-memory line port between the I-cache miss path and the D-cache

---
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares a single line-wide memory port between the I-cache miss path and the
// D-cache miss/writeback path. One line transaction is in flight at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no transaction, sampling requests, round-robin on a tie
// SERVE_I  | I-cache line read command on the memory port
// SERVE_D  | D-cache line read or writeback command on the memory port
// RESP     | one-cycle completion pulse to the owner, then back to IDLE
module cache_mem_arbiter #(
    parameter int LINE_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    // Clears the byte-offset bits so the memory always sees a line-aligned address.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    state_t                state;
    state_t                state_next;
    logic                  last_grant;   // 0 = I side, 1 = D side
    logic                  owner;        // side of the transaction in flight
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  d_req;
    logic                  grant_valid;
    logic                  grant_d;
    logic                  serving;

    assign d_req   = d_read | d_write;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    // Next-state and grant decision; a tie goes to the side that did not win last.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_d     = 1'b0;
        case (state)
            IDLE: begin
                if (i_read && d_req) begin
                    grant_valid = 1'b1;
                    grant_d     = ~last_grant;
                end else if (i_read) begin
                    grant_valid = 1'b1;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_d     = 1'b1;
                end
                if (grant_valid) begin
                    state_next = grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the command at grant and the read line at completion; later input
    // changes from the owner are deliberately ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b0;
            owner      <= 1'b0;
            is_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if ((state == IDLE) && grant_valid) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                // read+write both high from the D side resolves to a writeback
                is_write   <= grant_d & d_write;
                addr_q     <= (grant_d ? d_address : i_address) & LINE_MASK;
                wdata_q    <= d_wdata;
            end
            if (serving && pmem_resp) begin
                rdata_q <= is_write ? '0 : pmem_rdata;
            end
        end
    end

    assign pmem_read    = serving & ~is_write;
    assign pmem_write   = serving & is_write;
    assign pmem_address = serving ? addr_q : '0;
    assign pmem_wdata   = (serving && is_write) ? wdata_q : '0;
    assign i_resp       = (state == RESP) & ~owner;
    assign d_resp       = (state == RESP) & owner;
    assign i_rdata      = i_resp ? rdata_q : '0;
    assign d_rdata      = d_resp ? rdata_q : '0;
    assign busy         = (state != IDLE);

endmodule
